// File: rtl/t09_bin_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// t09_bin_to_bcd_seq_if
//   Groups the request/result signals of the sequential binary-to-BCD
//   converter.
//
//   Signals
//     start         request conversion of bin_in (master -> slave)
//     bin_in        unsigned binary value, WIDTH bits (master -> slave)
//     busy          conversion in progress (slave -> master)
//     done          one-cycle result-valid pulse (slave -> master)
//     bcd_ones      BCD ones digit (slave -> master)
//     bcd_tens      BCD tens digit (slave -> master)
//     bcd_hundreds  BCD hundreds digit (slave -> master)
//
//   Modports
//     master  requester side (e.g. the display controller or a testbench)
//     slave   converter side
// ---------------------------------------------------------------------------
interface t09_bin_to_bcd_seq_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [3:0]       bcd_ones;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_hundreds;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_ones,
        input  bcd_tens,
        input  bcd_hundreds
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_ones,
        output bcd_tens,
        output bcd_hundreds
    );

endinterface

// File: rtl/t09_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// t09_bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Produces three BCD digits (ones, tens, hundreds) for the multiplexed
//   display stage. The digit outputs are registered and only change on the
//   completion edge, so the display never sees a partially converted value.
//
//   Parameters
//     WIDTH   width of bin_in, legal range 1..9 (511 still fits 3 digits)
//
//   Ports
//     clk     clock
//     rst     asynchronous, active-low reset
//     bus     t09_bin_to_bcd_seq_if slave modport:
//               start, bin_in          request inputs
//               busy, done, bcd_*      registered status/result outputs
//
//   Timing
//     start accepted on edge E0 (only in IDLE) -> one iteration per edge,
//     result and a one-cycle done pulse appear after edge E0+WIDTH.
//     Holding start high gives one conversion every WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module t09_bin_to_bcd_seq #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    t09_bin_to_bcd_seq_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > 9) begin : g_bad_width
            $error("t09_bin_to_bcd_seq: WIDTH must be in 1..9");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    // Registered state
    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [11:0]      scratch;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [11:0]      bcd_q;

    // Next-state values
    state_t           state_next;
    logic [WIDTH-1:0] shift_next;
    logic [11:0]      scratch_next;
    logic [CW-1:0]    cnt_next;
    logic             busy_next;
    logic             done_next;
    logic [11:0]      bcd_next;

    // Datapath intermediates for one double-dabble iteration
    logic [11:0]      scratch_adj;
    logic [11:0]      scratch_shifted;

    // Add 3 to every nibble that is 5 or more; each nibble wraps on its own,
    // nothing carries into the next digit.
    function automatic logic [11:0] add3_digits(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int unsigned i = 0; i < 3; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        scratch_adj     = add3_digits(scratch);
        // Shift {scratch, shift_reg} left by one: MSB of the binary operand
        // enters the BCD LSB; the bit leaving the hundreds nibble is always 0.
        scratch_shifted = 12'({scratch_adj, shift_reg[WIDTH-1]});
    end

    // Next-state and output logic
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        scratch_next = scratch;
        cnt_next     = cnt;
        busy_next    = busy_q;
        done_next    = 1'b0;
        bcd_next     = bcd_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    shift_next   = bus.bin_in;
                    scratch_next = '0;
                    cnt_next     = CW'(WIDTH);
                    busy_next    = 1'b1;
                    state_next   = CONVERT;
                end
            end

            CONVERT: begin
                scratch_next = scratch_shifted;
                shift_next   = shift_reg << 1;
                cnt_next     = cnt - 1'b1;
                // Last iteration: publish the post-iteration scratch directly
                // so the result lands on the same edge as the final shift.
                if (cnt == CW'(1)) begin
                    bcd_next   = scratch_shifted;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            scratch   <= scratch_next;
            cnt       <= cnt_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
            bcd_q     <= bcd_next;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.bcd_ones     = bcd_q[3:0];
    assign bus.bcd_tens     = bcd_q[7:4];
    assign bus.bcd_hundreds = bcd_q[11:8];

endmodule

// File: tb/tb_t09_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_t09_bin_to_bcd_seq
//   Directed bench for the sequential binary-to-BCD converter. A timing model
//   (countdown from acceptance, digits from decimal arithmetic) is compared
//   against the DUT on every falling edge; directed scenarios add literal
//   expectations for digits, latency, busy length and done period.
// ---------------------------------------------------------------------------
module tb_t09_bin_to_bcd_seq;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    t09_bin_to_bcd_seq_if #(.WIDTH(WIDTH)) bus ();

    t09_bin_to_bcd_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_rem  = 0;
    int         m_val  = 0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [3:0] m_h    = '0;
    logic [3:0] m_t    = '0;
    logic [3:0] m_o    = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rem  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_h    <= '0;
            m_t    <= '0;
            m_o    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_h    <= 4'(m_val / 100);
                    m_t    <= 4'((m_val / 10) % 10);
                    m_o    <= 4'(m_val % 10);
                end
            end else if (bus.start) begin
                m_val  <= int'(bus.bin_in);
                m_rem  <= WIDTH;
                m_busy <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        chk("busy",      int'(bus.busy),         int'(m_busy));
        chk("done",      int'(bus.done),         int'(m_done));
        chk("hundreds",  int'(bus.bcd_hundreds), int'(m_h));
        chk("tens",      int'(bus.bcd_tens),     int'(m_t));
        chk("ones",      int'(bus.bcd_ones),     int'(m_o));
        chk("done_twice", int'(bus.done && prev_done), 0);
        prev_done <= bus.done;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen; cycles = edges taken.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 40) begin
            tick();
            cycles++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_digits(input string tag, input int h, input int t, input int o);
        chk({tag, "_hundreds"}, int'(bus.bcd_hundreds), h);
        chk({tag, "_tens"},     int'(bus.bcd_tens),     t);
        chk({tag, "_ones"},     int'(bus.bcd_ones),     o);
    endtask

    // Single-pulse conversion with latency and busy-length checks.
    task automatic run_and_check(input string tag, input int v,
                                 input int h, input int t, input int o);
        int lat;
        int busy_cnt;
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(v);
        tick();
        bus.start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, WIDTH);
        chk({tag, "_busy_len"}, busy_cnt, WIDTH);
        check_digits(tag, h, t, o);
        tick();
        chk({tag, "_done_drop"}, int'(bus.done), 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int c;
        int quiet_done;

        bus.start  = 1'b0;
        bus.bin_in = '0;

        repeat (3) tick();
        rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_busy", int'(bus.busy), 0);
            chk("idle_done", int'(bus.done), 0);
            check_digits("idle", 0, 0, 0);
        end

        // Single conversions
        run_and_check("v255", 255, 2, 5, 5);
        run_and_check("v0",     0, 0, 0, 0);
        run_and_check("v128", 128, 1, 2, 8);
        run_and_check("v9",     9, 0, 0, 9);

        // Start held high, operand swapped at each done
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(200);
        wait_done(c);
        check_digits("held200a", 2, 0, 0);
        bus.bin_in = WIDTH'(37);
        tick();
        wait_done(c);
        chk("held_period1", c + 1, WIDTH + 1);
        check_digits("held37", 0, 3, 7);
        bus.bin_in = WIDTH'(200);
        tick();
        wait_done(c);
        chk("held_period2", c + 1, WIDTH + 1);
        check_digits("held200b", 2, 0, 0);
        bus.start = 1'b0;
        tick();
        tick();
        chk("held_stop_busy", int'(bus.busy), 0);

        // start/bin_in changes while busy are ignored
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(42);
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(99);
        tick();
        bus.start = 1'b0;
        wait_done(c);
        check_digits("ignore99", 0, 4, 2);
        tick();

        // Reset in the 4th CONVERT cycle aborts the conversion
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(150);
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        check_digits("rst", 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        quiet_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) quiet_done++;
        end
        chk("rst_no_done", quiet_done, 0);
        run_and_check("v150", 150, 1, 5, 0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
